spike_readout: RTL
==================

# spike_readout

Downstream stage of the recurrent state accumulator. Samples the 8-bit accumulated state every valid cycle, fires a one-cycle spike when the state reaches a runtime threshold, and enforces a refractory period after each spike. Spikes are counted over a fixed window of valid samples, and each window's count is handed to the consumer through a valid/ready register.

## Interface
- `WIDTH`, 8, width of the sampled state and of the threshold
- `REFRAC`, 3, refractory cycles after a spike; 0 disables the refractory period
- `WINDOW`, 16, valid samples per counting window; must be ≥1
- `CNT_W`, 8, width of the spike count
- `clk`  in  1  clock; all registers update on the rising edge
- `rst_n`  in  1  reset: one clock; asynchronous, active-low
- `state_in`  in  WIDTH  accumulated state from the upstream stage, unsigned
- `state_valid`  in  1  `state_in` is a sample this cycle
- `threshold`  in  WIDTH  spike threshold, unsigned; sampled every cycle
- `spike`  out  1  registered one-cycle spike pulse
- `count_data`  out  CNT_W  spike count of the completed window
- `count_valid`  out  1  `count_data` holds an unconsumed count
- `count_ready`  in  1  consumer accepts `count_data`
- `dropped`  out  1  sticky flag: a window count was lost

## Operation
- FSM states:
  - ARMED: if `state_valid` and `state_in >= threshold`, fire a spike.
    - If `REFRAC > 0`, load the refractory counter with `REFRAC` and go to REFRACT.
    - Otherwise stay in ARMED.
  - REFRACT: decrement the refractory counter every cycle, whether or not `state_valid` is high. On the cycle the counter goes from 1 to 0, return to ARMED; a sample in that same cycle is still ignored for spiking. Samples in REFRACT never spike but do count toward the window.
- Window counter:
  - Increments on every cycle with `state_valid=1`.
  - On the `WINDOW`-th valid sample, the window closes and the counter returns to 0.
- Spike counter:
  - Increments on each fired spike and saturates at 2^CNT_W−1.
  - When a window closes, the count transferred includes any spike fired by the closing sample, and the spike counter restarts at 0.
- Output register:
  - Handshake completes when `count_valid && count_ready`.
  - At window close, if the register is empty, or is being emptied by a handshake in the same cycle, load the count and set `count_valid=1`.
  - Otherwise discard the new count, set `dropped=1`, and keep the existing `count_data` unchanged.
  - `count_valid` clears on a handshake with no simultaneous load.
  - `count_data` must not change while `count_valid=1` and no handshake has occurred.
- `dropped` clears only on reset.
- Threshold comparison is unsigned, full WIDTH. `threshold=0` spikes on every valid ARMED sample.
- `count_ready` is ignored while `count_valid=0`.

## Timing
- Reset values:
  - `spike=0`, `count_data=0`, `count_valid=0`, `dropped=0`
  - FSM in ARMED; refractory, window and spike counters all 0
- Asserting `rst_n` low mid-window or mid-refractory clears everything immediately and discards any partial count.
- `spike` latency: high for exactly the one cycle after the edge that takes the qualifying sample.
- `count_valid` latency: rises in the cycle after the edge that takes the closing sample.
- Earliest re-spike after a spike at edge t: a sample at edge t+REFRAC+1.
  - With `REFRAC=0`, consecutive qualifying samples give `spike` high on consecutive cycles.
- Throughput: one sample per cycle. Back-to-back window closes with `count_ready` tied high lose no count.
- Simultaneous window close, handshake and spike: the old count is consumed, the new count (including that spike) is loaded, and `count_valid` stays 1.

## Test plan
- Reset, then 16 valid samples of `state_in=0x10` with `threshold=0x80` -> `spike` never rises; `count_data=0` with `count_valid=1` the cycle after the 16th sample; `dropped=0`.
- `threshold=0x80`, 16 consecutive samples of `0x90`, REFRAC=3 -> spikes on samples 1,5,9,13; `count_data=4`.
- REFRAC=0 build, 16 samples of `0xFF` at `threshold=0` -> `spike` high 16 consecutive cycles; `count_data=16`.
- `count_ready=0` across two window closes -> first count held stable; second discarded; `dropped=1`. Then `count_ready=1` -> first count accepted, `count_valid` falls.
- Window closes on a qualifying sample in the same cycle the consumer handshakes a pending count -> `count_valid` stays 1; new `count_data` includes the closing spike.
- `rst_n` pulsed low during REFRACT after 7 samples -> all outputs 0 immediately; the next 16 samples form a fresh window with an immediate first spike.

Source files
------------

// File: rtl/spike_readout.sv
// spike_readout: threshold spike generator with refractory period and a
// windowed spike counter that hands each window's count to a consumer
// through a single valid/ready output register.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   state_in      sampled accumulator state (unsigned, WIDTH bits)
//   state_valid   state_in carries a sample this cycle
//   threshold     spike threshold (unsigned, WIDTH bits)
//   spike         registered one-cycle spike pulse
//   count_data    spike count of the most recently loaded window
//   count_valid   count_data holds an unconsumed count
//   count_ready   consumer accepts count_data
//   dropped       sticky: a window count was discarded
module spike_readout #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned REFRAC = 3,
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] state_in,
    input  logic             state_valid,
    input  logic [WIDTH-1:0] threshold,
    output logic             spike,
    output logic [CNT_W-1:0] count_data,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             dropped
);

    localparam int unsigned RC_W = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);
    localparam int unsigned WC_W = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        ARMED   = 1'b0,
        REFRACT = 1'b1
    } fsm_t;

    fsm_t            fsm_state;
    fsm_t            fsm_next;
    logic [RC_W-1:0] refrac_cnt;
    logic [RC_W-1:0] refrac_next;

    logic [WC_W-1:0]  win_cnt;
    logic [CNT_W-1:0] spk_cnt;

    logic             qualify_c;
    logic             fire_c;
    logic             win_close_c;
    logic             handshake_c;
    logic             load_c;
    logic [CNT_W-1:0] spk_inc_c;
    logic [CNT_W-1:0] spk_total_c;

    assign qualify_c = state_valid && (state_in >= threshold);

    // FSM state and refractory counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_state  <= ARMED;
            refrac_cnt <= '0;
        end else begin
            fsm_state  <= fsm_next;
            refrac_cnt <= refrac_next;
        end
    end

    // Next-state: the refractory counter runs every cycle, valid or not
    always_comb begin
        fsm_next    = fsm_state;
        refrac_next = refrac_cnt;
        case (fsm_state)
            ARMED: begin
                if (qualify_c && (REFRAC != 0)) begin
                    fsm_next    = REFRACT;
                    refrac_next = RC_W'(REFRAC);
                end
            end
            REFRACT: begin
                refrac_next = refrac_cnt - RC_W'(1);
                if (refrac_cnt == RC_W'(1)) begin
                    fsm_next = ARMED;
                end
            end
            default: begin
                fsm_next    = ARMED;
                refrac_next = '0;
            end
        endcase
    end

    // FSM output: only an armed qualifying sample fires
    always_comb begin
        fire_c = 1'b0;
        if (fsm_state == ARMED) begin
            fire_c = qualify_c;
        end
    end

    // Window close and the count it transfers (includes a closing spike)
    assign win_close_c = state_valid && (win_cnt == WC_W'(WINDOW - 1));
    assign spk_inc_c   = (spk_cnt == CNT_MAX) ? spk_cnt : spk_cnt + CNT_W'(1);
    assign spk_total_c = fire_c ? spk_inc_c : spk_cnt;
    assign handshake_c = count_valid && count_ready;
    assign load_c      = win_close_c && (!count_valid || handshake_c);

    // Spike pulse and window/spike counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike   <= 1'b0;
            win_cnt <= '0;
            spk_cnt <= '0;
        end else begin
            spike <= fire_c;
            if (win_close_c) begin
                win_cnt <= '0;
                spk_cnt <= '0;
            end else begin
                if (state_valid) begin
                    win_cnt <= win_cnt + WC_W'(1);
                end
                spk_cnt <= spk_total_c;
            end
        end
    end

    // Output register: load when empty or emptying, otherwise drop the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_data  <= '0;
            count_valid <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            if (load_c) begin
                count_data  <= spk_total_c;
                count_valid <= 1'b1;
            end else if (handshake_c) begin
                count_valid <= 1'b0;
            end
            if (win_close_c && !load_c) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule
